// File: rtl/move_engine_if.sv
// Handshake and result bundle between the move decoder and move_engine.
//   master: drives move_req / pl_move / pp_restore, observes results.
//   slave : move_engine side.
interface move_engine_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DMG_W = 4,
  parameter int unsigned PP_W  = 4
) ();
  logic             move_req;
  logic [SEL_W-1:0] pl_move;
  logic             pp_restore;
  logic             move_ready;
  logic             move_done;
  logic [DMG_W-1:0] dmg;
  logic [3:0]       accu;
  logic             hit;
  logic             no_pp;
  logic             bad_move;
  logic [PP_W-1:0]  pp_left;

  modport master (
    output move_req, pl_move, pp_restore,
    input  move_ready, move_done, dmg, accu, hit, no_pp, bad_move, pp_left
  );

  modport slave (
    input  move_req, pl_move, pp_restore,
    output move_ready, move_done, dmg, accu, hit, no_pp, bad_move, pp_left
  );
endinterface

// File: rtl/move_engine.sv
// Move-resolution engine: latches a move request, looks up damage/accuracy/PP
// from parameter tables, tracks remaining PP per slot, rolls hit/miss against
// a 4-bit LFSR and presents the result with a one-cycle move_done pulse.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - move_engine_if.slave: request (move_req, pl_move, pp_restore),
//            status (move_ready, move_done) and results (dmg, accu, hit,
//            no_pp, bad_move, pp_left)
module move_engine #(
  parameter int unsigned                 NUM_MOVES = 4,
  parameter int unsigned                 SEL_W     = 2,
  parameter int unsigned                 DMG_W     = 4,
  parameter int unsigned                 PP_W      = 4,
  parameter logic [NUM_MOVES*DMG_W-1:0] DMG_TABLE = {4'd11, 4'd5, 4'd3, 4'd1},
  parameter logic [NUM_MOVES*4-1:0]     ACC_TABLE = {4'd3, 4'd7, 4'd8, 4'd10},
  parameter logic [NUM_MOVES*PP_W-1:0]  PP_TABLE  = {4'd5, 4'd10, 4'd15, 4'd15},
  parameter logic [3:0]                 LFSR_SEED = 4'b0001
) (
  input logic          clk,
  input logic          resetn,
  move_engine_if.slave bus
);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [3:0] SeedEff = (LFSR_SEED == 4'd0) ? 4'b0001 : LFSR_SEED;

  typedef enum logic [1:0] {StIdle, StLookup, StResolve} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [3:0]       lfsr_q;
  logic [PP_W-1:0]  pp_q [NUM_MOVES];

  // Table values registered during LOOKUP.
  logic [DMG_W-1:0] tdmg_q;
  logic [3:0]       tacc_q;
  logic             bad_q;

  // Last result, held between done pulses.
  logic [DMG_W-1:0] dmg_q;
  logic [3:0]       accu_q;
  logic             hit_q, no_pp_q, bad_move_q;
  logic [PP_W-1:0]  pp_left_q;

  logic [DMG_W-1:0] lk_dmg;
  logic [3:0]       lk_acc;
  logic [PP_W-1:0]  lk_pp_max, cur_pp;
  logic             sel_valid;

  logic             done, pp_dec;
  logic [DMG_W-1:0] res_dmg;
  logic [3:0]       res_acc;
  logic             res_hit, res_no_pp, res_bad;
  logic [PP_W-1:0]  res_pp;

  // Slot lookup; out-of-range selects leave everything at zero.
  always_comb begin
    lk_dmg    = '0;
    lk_acc    = '0;
    lk_pp_max = '0;
    cur_pp    = '0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        lk_dmg    = DMG_TABLE[i*DMG_W +: DMG_W];
        lk_acc    = ACC_TABLE[i*4 +: 4];
        lk_pp_max = PP_TABLE[i*PP_W +: PP_W];
        cur_pp    = pp_q[i];
      end
    end
  end

  assign sel_valid = (32'(sel_q) < NUM_MOVES);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.move_req) state_d = StLookup;
      StLookup:  state_d = StResolve;
      StResolve: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign done = (state_q == StResolve);

  // Resolution. PP is read live in RESOLVE so a restore during LOOKUP is seen.
  always_comb begin
    res_dmg   = '0;
    res_acc   = '0;
    res_hit   = 1'b0;
    res_no_pp = 1'b0;
    res_bad   = 1'b0;
    res_pp    = '0;
    pp_dec    = 1'b0;
    if (bad_q) begin
      res_bad = 1'b1;
    end else if (cur_pp == '0) begin
      // Struggle
      res_dmg   = DMG_W'(1);
      res_acc   = 4'hF;
      res_hit   = 1'b1;
      res_no_pp = 1'b1;
    end else begin
      res_acc = tacc_q;
      res_hit = (lfsr_q <= tacc_q);
      res_dmg = res_hit ? tdmg_q : '0;
      pp_dec  = done;
      // A coinciding restore wins over the decrement.
      res_pp  = bus.pp_restore ? lk_pp_max : (cur_pp - PP_W'(1));
    end
  end

  assign bus.move_ready = (state_q == StIdle);
  assign bus.move_done  = done;
  assign bus.dmg        = done ? res_dmg   : dmg_q;
  assign bus.accu       = done ? res_acc   : accu_q;
  assign bus.hit        = done ? res_hit   : hit_q;
  assign bus.no_pp      = done ? res_no_pp : no_pp_q;
  assign bus.bad_move   = done ? res_bad   : bad_move_q;
  assign bus.pp_left    = done ? res_pp    : pp_left_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      lfsr_q     <= SeedEff;
      tdmg_q     <= '0;
      tacc_q     <= '0;
      bad_q      <= 1'b0;
      dmg_q      <= '0;
      accu_q     <= '0;
      hit_q      <= 1'b0;
      no_pp_q    <= 1'b0;
      bad_move_q <= 1'b0;
      pp_left_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      if (state_q == StIdle && bus.move_req) begin
        sel_q <= bus.pl_move;
      end
      if (state_q == StLookup) begin
        tdmg_q <= lk_dmg;
        tacc_q <= lk_acc;
        bad_q  <= !sel_valid;
      end
      if (done) begin
        dmg_q      <= res_dmg;
        accu_q     <= res_acc;
        hit_q      <= res_hit;
        no_pp_q    <= res_no_pp;
        bad_move_q <= res_bad;
        pp_left_q  <= res_pp;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_MOVES; i++) pp_q[i] <= PP_TABLE[i*PP_W +: PP_W];
    end else if (bus.pp_restore) begin
      for (int i = 0; i < NUM_MOVES; i++) pp_q[i] <= PP_TABLE[i*PP_W +: PP_W];
    end else if (pp_dec) begin
      for (int i = 0; i < NUM_MOVES; i++) begin
        if (sel_q == SEL_W'(i)) pp_q[i] <= cur_pp - PP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_move_engine.sv
module tb_move_engine;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int         dut;
  logic       req, rst_pp;
  logic [1:0] pm;

  move_engine_if if_a ();
  move_engine_if if_b ();
  move_engine_if if_c ();

  assign if_a.move_req   = req && (dut == 0);
  assign if_b.move_req   = req && (dut == 1);
  assign if_c.move_req   = req && (dut == 2);
  assign if_a.pp_restore = rst_pp && (dut == 0);
  assign if_b.pp_restore = rst_pp && (dut == 1);
  assign if_c.pp_restore = rst_pp && (dut == 2);
  assign if_a.pl_move    = pm;
  assign if_b.pl_move    = pm;
  assign if_c.pl_move    = pm;

  // Default tables.
  move_engine u_a (.clk(clk), .resetn(resetn), .bus(if_a));

  // Three slots, slot0 always hits: dmg {5,3,1}, acc {7,8,15}, pp {10,15,15}.
  move_engine #(
    .NUM_MOVES(3),
    .DMG_TABLE({4'd5, 4'd3, 4'd1}),
    .ACC_TABLE({4'd7, 4'd8, 4'd15}),
    .PP_TABLE ({4'd10, 4'd15, 4'd15})
  ) u_b (.clk(clk), .resetn(resetn), .bus(if_b));

  // Slot0 accuracy 0: never hits.
  move_engine #(
    .ACC_TABLE({4'd3, 4'd7, 4'd8, 4'd0})
  ) u_c (.clk(clk), .resetn(resetn), .bus(if_c));

  logic       o_ready, o_done, o_hit, o_no_pp, o_bad;
  logic [3:0] o_dmg, o_accu, o_pp;

  always_comb begin
    case (dut)
      1: begin
        o_ready = if_b.move_ready; o_done = if_b.move_done; o_hit = if_b.hit;
        o_no_pp = if_b.no_pp; o_bad = if_b.bad_move; o_dmg = if_b.dmg;
        o_accu = if_b.accu; o_pp = if_b.pp_left;
      end
      2: begin
        o_ready = if_c.move_ready; o_done = if_c.move_done; o_hit = if_c.hit;
        o_no_pp = if_c.no_pp; o_bad = if_c.bad_move; o_dmg = if_c.dmg;
        o_accu = if_c.accu; o_pp = if_c.pp_left;
      end
      default: begin
        o_ready = if_a.move_ready; o_done = if_a.move_done; o_hit = if_a.hit;
        o_no_pp = if_a.no_pp; o_bad = if_a.bad_move; o_dmg = if_a.dmg;
        o_accu = if_a.accu; o_pp = if_a.pp_left;
      end
    endcase
  end

  // Reference LFSR: all DUTs share seed, clock and reset.
  logic [3:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 4'b0001;
    else         m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  int n_checks = 0;
  int n_fail = 0;

  logic       r_hit, r_no_pp, r_bad, got_done, ready_low, ready_after, done_after;
  logic [3:0] r_dmg, r_accu, r_pp, r_roll, held_pp;
  int         done_cyc;

  task automatic do_move(input int d, input logic [1:0] m, input bit restore_in_resolve);
    int cyc;
    dut = d; pm = m; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1;
    ready_low = (o_ready == 1'b0);
    while (!o_done && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2 && restore_in_resolve) begin rst_pp = 1'b1; #1; end
      if (cyc <= 2 && o_ready) ready_low = 1'b0;
    end
    got_done = o_done; done_cyc = cyc;
    r_dmg = o_dmg; r_accu = o_accu; r_hit = o_hit; r_no_pp = o_no_pp;
    r_bad = o_bad; r_pp = o_pp; r_roll = m_lfsr;
    @(posedge clk); #1;
    rst_pp = 1'b0;
    ready_after = o_ready; done_after = o_done; held_pp = o_pp;
  endtask

  task automatic pulse_restore(input int d);
    dut = d; rst_pp = 1'b1;
    @(posedge clk); #1;
    rst_pp = 1'b0;
  endtask

  task automatic test_reset;
    dut = 0;
    resetn = 1'b0;
    #12;
    n_checks++;
    if ({o_ready, o_done} !== 2'b10) begin
      n_fail++; $display("FAIL reset_handshake: got ready/done %b%b expected 10", o_ready, o_done);
    end
    n_checks++;
    if ({o_dmg, o_accu, o_hit, o_no_pp, o_bad, o_pp} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dmg %0d accu %0d hit %b no_pp %b bad %b pp %0d expected all 0",
               o_dmg, o_accu, o_hit, o_no_pp, o_bad, o_pp);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_first;
    logic       exp_hit;
    logic [3:0] exp_dmg;
    do_move(0, 2'd2, 1'b0);
    exp_hit = (r_roll <= 4'd7);
    exp_dmg = exp_hit ? 4'd5 : 4'd0;
    n_checks++;
    if (!got_done || done_cyc != 2) begin
      n_fail++; $display("FAIL first_latency: done seen %b in cycle %0d expected cycle 2", got_done, done_cyc);
    end
    n_checks++;
    if (ready_low !== 1'b1) begin
      n_fail++; $display("FAIL first_ready_low: got %b expected 1 (ready low cycles 1-2)", ready_low);
    end
    n_checks++;
    if ({ready_after, done_after} !== 2'b10) begin
      n_fail++; $display("FAIL first_cycle3: got ready/done %b%b expected 10", ready_after, done_after);
    end
    n_checks++;
    if ({r_accu, r_pp} !== {4'd7, 4'd9}) begin
      n_fail++; $display("FAIL first_accu_pp: got accu %0d pp %0d expected 7 9", r_accu, r_pp);
    end
    n_checks++;
    if ({r_hit, r_dmg, r_no_pp, r_bad} !== {exp_hit, exp_dmg, 2'b00}) begin
      n_fail++;
      $display("FAIL first_hit_dmg: roll %0d got hit %b dmg %0d no_pp %b bad %b expected hit %b dmg %0d 0 0",
               r_roll, r_hit, r_dmg, r_no_pp, r_bad, exp_hit, exp_dmg);
    end
    n_checks++;
    if (held_pp !== 4'd9) begin
      n_fail++; $display("FAIL first_hold: got pp_left %0d after done expected 9", held_pp);
    end
  endtask

  task automatic test_drain;
    logic       exp_hit;
    logic [3:0] exp_dmg;
    for (int k = 0; k < 5; k++) begin
      do_move(0, 2'd3, 1'b0);
      exp_hit = (r_roll <= 4'd3);
      exp_dmg = exp_hit ? 4'd11 : 4'd0;
      n_checks++;
      if ({r_pp, r_accu, r_hit, r_dmg, r_no_pp} !== {4'(4 - k), 4'd3, exp_hit, exp_dmg, 1'b0}) begin
        n_fail++;
        $display("FAIL drain_%0d: got pp %0d accu %0d hit %b dmg %0d no_pp %b expected pp %0d accu 3 hit %b dmg %0d",
                 k, r_pp, r_accu, r_hit, r_dmg, r_no_pp, 4 - k, exp_hit, exp_dmg);
      end
    end
    do_move(0, 2'd3, 1'b0);
    n_checks++;
    if ({r_no_pp, r_dmg, r_accu, r_hit, r_pp, r_bad} !== {1'b1, 4'd1, 4'd15, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL struggle: got no_pp %b dmg %0d accu %0d hit %b pp %0d bad %b expected 1 1 15 1 0 0",
               r_no_pp, r_dmg, r_accu, r_hit, r_pp, r_bad);
    end
  endtask

  task automatic test_restore;
    pulse_restore(0);
    do_move(0, 2'd3, 1'b0);
    n_checks++;
    if ({r_no_pp, r_pp} !== {1'b0, 4'd4}) begin
      n_fail++; $display("FAIL restore: got no_pp %b pp %0d expected 0 4", r_no_pp, r_pp);
    end
  endtask

  task automatic test_restore_collision;
    do_move(0, 2'd3, 1'b1);
    n_checks++;
    if (r_pp !== 4'd5) begin
      n_fail++; $display("FAIL collision_pp_left: got %0d expected 5", r_pp);
    end
    do_move(0, 2'd3, 1'b0);
    n_checks++;
    if (r_pp !== 4'd4) begin
      n_fail++; $display("FAIL collision_counter: got %0d expected 4", r_pp);
    end
  endtask

  task automatic test_bad_move;
    do_move(1, 2'd3, 1'b0);
    n_checks++;
    if (!got_done || done_cyc != 2) begin
      n_fail++; $display("FAIL bad_done: seen %b cycle %0d expected cycle 2", got_done, done_cyc);
    end
    n_checks++;
    if ({r_bad, r_dmg, r_accu, r_hit, r_pp, r_no_pp} !== {1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_outputs: got bad %b dmg %0d accu %0d hit %b pp %0d no_pp %b expected 1 0 0 0 0 0",
               r_bad, r_dmg, r_accu, r_hit, r_pp, r_no_pp);
    end
    for (int s = 0; s < 3; s++) begin
      do_move(1, 2'(s), 1'b0);
      n_checks++;
      if ({r_bad, r_pp} !== {1'b0, (s == 2) ? 4'd9 : 4'd14}) begin
        n_fail++; $display("FAIL bad_pp_slot%0d: got bad %b pp %0d expected 0 %0d",
                           s, r_bad, r_pp, (s == 2) ? 9 : 14);
      end
    end
  endtask

  task automatic test_acc_extremes;
    for (int i = 0; i < 30; i++) begin
      if (i % 14 == 0) pulse_restore(1);
      do_move(1, 2'd0, 1'b0);
      n_checks++;
      if ({r_hit, r_dmg, r_accu, r_no_pp} !== {1'b1, 4'd1, 4'd15, 1'b0}) begin
        n_fail++; $display("FAIL acc15_%0d: roll %0d got hit %b dmg %0d accu %0d no_pp %b expected 1 1 15 0",
                           i, r_roll, r_hit, r_dmg, r_accu, r_no_pp);
      end
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 14 == 0) pulse_restore(2);
      do_move(2, 2'd0, 1'b0);
      n_checks++;
      if ({r_hit, r_dmg, r_accu, r_no_pp} !== {1'b0, 4'd0, 4'd0, 1'b0}) begin
        n_fail++; $display("FAIL acc0_%0d: roll %0d got hit %b dmg %0d accu %0d no_pp %b expected 0 0 0 0",
                           i, r_roll, r_hit, r_dmg, r_accu, r_no_pp);
      end
    end
  endtask

  task automatic test_busy;
    int n_done;
    n_done = 0;
    dut = 0; pm = 2'd1; req = 1'b1;
    @(posedge clk); #1;
    pm = 2'd0;  // still requesting while in LOOKUP
    for (int c = 0; c < 6; c++) begin
      if (o_done) begin n_done++; r_pp = o_pp; end
      @(posedge clk); #1;
      if (c == 0) req = 1'b0;
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL busy_done_count: got %0d expected 1", n_done);
    end
    n_checks++;
    if (r_pp !== 4'd14) begin
      n_fail++; $display("FAIL busy_slot1_pp: got %0d expected 14", r_pp);
    end
    do_move(0, 2'd0, 1'b0);
    n_checks++;
    if (r_pp !== 4'd14) begin
      n_fail++; $display("FAIL busy_slot0_untouched: got %0d expected 14", r_pp);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    do_move(0, 2'd2, 1'b0);
    n_checks++;
    if (r_pp !== 4'd9) begin
      n_fail++; $display("FAIL rmid_pre_pp: got %0d expected 9", r_pp);
    end
    dut = 0; pm = 2'd2; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    resetn = 1'b0;  // in LOOKUP
    for (int c = 0; c < 3; c++) begin
      #1;
      if (o_done) n_done++;
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready: got %b expected 1", o_ready);
    end
    for (int c = 0; c < 3; c++) begin
      if (o_done) n_done++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", n_done);
    end
    do_move(0, 2'd2, 1'b0);
    n_checks++;
    if (r_pp !== 4'd9) begin
      n_fail++; $display("FAIL rmid_reload: got pp %0d expected 9", r_pp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dut = 0; req = 1'b0; rst_pp = 1'b0; pm = 2'd0;
    test_reset();
    test_first();
    test_drain();
    test_restore();
    test_restore_collision();
    test_bad_move();
    test_acc_extremes();
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
